aig_eval_engine: RTL and testbench

AIG_EVAL_ENGINE -- requirements
Module: aig_eval_engine

---
 rtl/aig_eval_pkg.sv | 37 +++
 rtl/aig_node_ram.sv | 25 ++
 rtl/aig_eval_engine.sv | 175 +++++++++++++++++
 tb/tb_aig_eval_engine.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/aig_eval_pkg.sv
// rtl/aig_eval_pkg.sv - shared literal/node types, FSM states and literal-space bases for the AIG evaluator
package aig_eval_pkg;

    localparam int LIT_IDX_MAX_W = 16;
    localparam int LIT_CONST0    = 0;
    localparam int LIT_IN_BASE   = 1;

    typedef struct packed {
        logic                     inv;
        logic [LIT_IDX_MAX_W-1:0] idx;
    } lit_t;

    typedef struct packed {
        lit_t a;
        lit_t b;
    } node_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_MAP,
        ST_HOLD
    } state_t;

    // Node k lives at literal node_base(num_in) + k, right after the primary inputs.
    function automatic int node_base(input int num_in);
        return num_in + LIT_IN_BASE;
    endfunction

    function automatic lit_t make_lit(input logic inv, input logic [LIT_IDX_MAX_W-1:0] idx);
        lit_t l;
        l.inv = inv;
        l.idx = idx;
        return l;
    endfunction

endpackage

// File: rtl/aig_node_ram.sv
// rtl/aig_node_ram.sv - node operand memory, one synchronous write port and one combinational read port
module aig_node_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int DW    = 18
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/aig_eval_engine.sv
// rtl/aig_eval_engine.sv - sequential AND-inverter-graph evaluator, one node per cycle then output mapping
// Optional forward-reference check enabled by defining AIG_EVAL_FWDCHK_EN.
module aig_eval_engine
    import aig_eval_pkg::*;
#(
    parameter  int NUM_IN    = 6,
    parameter  int NUM_OUT   = 18,
    parameter  int MAX_NODES = 128,
    localparam int IDX_W     = $clog2(1 + NUM_IN + MAX_NODES),
    localparam int ADDR_W    = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1,
    localparam int NN_W      = $clog2(MAX_NODES + 1),
    localparam int MAP_AW    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [ADDR_W-1:0]    cfg_addr,
    input  logic [2*IDX_W+1:0]   cfg_data,
    input  logic                 map_we,
    input  logic [MAP_AW-1:0]    map_addr,
    input  logic [IDX_W:0]       map_data,
    input  logic [NN_W-1:0]      num_nodes,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUM_IN-1:0]    in_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_OUT-1:0]   out_vec,
    output logic                 cfg_err
);

    localparam int NODE_BASE = node_base(NUM_IN);

    state_t                 state, state_nxt;
    logic [NUM_IN-1:0]      in_lat;
    logic [NN_W-1:0]        nn_lat;
    logic [NN_W-1:0]        nn_clamped;
    logic [NN_W-1:0]        ptr;
    logic [MAX_NODES-1:0]   node_val;
    logic [IDX_W:0]         map_mem [NUM_OUT];
    logic [2*IDX_W+1:0]     node_rd;
    lit_t                   lit_a, lit_b;
    logic                   op_a, op_b, fwd_err;
    logic                   accept, last_node, wr_open, node_we, map_wr, wr_reject;
    logic [NUM_OUT-1:0]     map_val;

    // Anything outside the input and node ranges (including literal 0) evaluates to 0 before inversion.
    function automatic logic lit_value(input lit_t l, input logic [NUM_IN-1:0] iv,
                                       input logic [MAX_NODES-1:0] nv);
        int   i;
        logic v;
        i = int'(l.idx);
        v = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (i == LIT_IN_BASE + k) v = iv[k];
        end
        for (int k = 0; k < MAX_NODES; k++) begin
            if (i == NODE_BASE + k) v = nv[k];
        end
        return v ^ l.inv;
    endfunction

    assign nn_clamped = (num_nodes > NN_W'(MAX_NODES)) ? NN_W'(MAX_NODES) : num_nodes;
    assign accept     = in_valid && (state == ST_IDLE);
    assign last_node  = (ptr == nn_lat - NN_W'(1));
    assign wr_open    = (state == ST_IDLE) && !accept;
    assign node_we    = cfg_we && wr_open;
    assign map_wr     = map_we && wr_open;
    assign wr_reject  = (cfg_we || map_we) && !wr_open;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = (nn_clamped == '0) ? ST_MAP : ST_EVAL;
            end
            ST_EVAL: begin
                if (last_node) state_nxt = ST_MAP;
            end
            ST_MAP: begin
                state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    aig_node_ram #(
        .DEPTH (MAX_NODES),
        .AW    (ADDR_W),
        .DW    (2*IDX_W+2)
    ) u_node_ram (
        .clk   (clk),
        .we    (node_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (ptr[ADDR_W-1:0]),
        .rdata (node_rd)
    );

    assign lit_a = make_lit(node_rd[2*IDX_W+1], LIT_IDX_MAX_W'(node_rd[2*IDX_W:IDX_W+1]));
    assign lit_b = make_lit(node_rd[IDX_W], LIT_IDX_MAX_W'(node_rd[IDX_W-1:0]));

    always_comb begin
        op_a    = lit_value(lit_a, in_lat, node_val);
        op_b    = lit_value(lit_b, in_lat, node_val);
        fwd_err = 1'b0;
`ifdef AIG_EVAL_FWDCHK_EN
        // An operand at or beyond the node being evaluated has no settled value yet.
        if (state == ST_EVAL) begin
            if (int'(lit_a.idx) >= NODE_BASE + int'(ptr)) begin
                op_a    = 1'b0;
                fwd_err = 1'b1;
            end
            if (int'(lit_b.idx) >= NODE_BASE + int'(ptr)) begin
                op_b    = 1'b0;
                fwd_err = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        map_val = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            map_val[j] = lit_value(make_lit(map_mem[j][IDX_W], LIT_IDX_MAX_W'(map_mem[j][IDX_W-1:0])),
                                   in_lat, node_val);
        end
    end

    always_ff @(posedge clk) begin
        if (map_wr && (int'(map_addr) < NUM_OUT)) begin
            map_mem[map_addr] <= map_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_lat   <= '0;
            nn_lat   <= '0;
            ptr      <= '0;
            node_val <= '0;
            out_vec  <= '0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= wr_reject || fwd_err;
            if (accept) begin
                in_lat   <= in_vec;
                nn_lat   <= nn_clamped;
                ptr      <= '0;
                node_val <= '0;
            end else if (state == ST_EVAL) begin
                node_val[ptr[ADDR_W-1:0]] <= op_a & op_b;
                ptr                       <= ptr + NN_W'(1);
            end else if (state == ST_MAP) begin
                out_vec <= map_val;
            end
        end
    end

endmodule

// File: tb/tb_aig_eval_engine.sv
// tb/tb_aig_eval_engine.sv - directed self-checking bench for aig_eval_engine (NUM_IN=2, NUM_OUT=4, MAX_NODES=8)
module tb_aig_eval_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [9:0] cfg_data;
    logic       map_we;
    logic [1:0] map_addr;
    logic [4:0] map_data;
    logic [3:0] num_nodes;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_vec;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;
    int lat, errs, err_cnt;
    logic [3:0] ov;
    logic       ok;

    always #5 clk = ~clk;

    aig_eval_engine #(
        .NUM_IN    (2),
        .NUM_OUT   (4),
        .MAX_NODES (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .map_we    (map_we),
        .map_addr  (map_addr),
        .map_data  (map_data),
        .num_nodes (num_nodes),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .cfg_err   (cfg_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_node(input logic [2:0] a, input logic [9:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wr_map(input logic [1:0] a, input logic [4:0] d);
        @(negedge clk);
        map_we = 1'b1; map_addr = a; map_data = d;
        @(negedge clk);
        map_we = 1'b0;
    endtask

    task automatic start(input logic [1:0] iv, input logic [3:0] nn, input logic with_we);
        @(negedge clk);
        in_vec = iv; num_nodes = nn; in_valid = 1'b1;
        if (with_we) begin
            cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 10'h000;
        end
        @(negedge clk);
        in_valid = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic finish(output int l, output logic [3:0] v, output int e);
        l = 1;
        e = int'(cfg_err);
        while (!out_valid && l < 100) begin
            @(negedge clk);
            l++;
            e += int'(cfg_err);
        end
        v = out_vec;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        map_we = 1'b0; map_addr = '0; map_data = '0; num_nodes = '0;
        in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_vec", 32'(out_vec), 0);
        check("rst_cfg_err", 32'(cfg_err), 0);

        // n0=~in1&~in2, n1=in1&in2, n2=~n0&~n1 (xor), n4 refers forward to n5
        wr_node(3'd0, {1'b1, 4'd1, 1'b1, 4'd2});
        wr_node(3'd1, {1'b0, 4'd1, 1'b0, 4'd2});
        wr_node(3'd2, {1'b1, 4'd3, 1'b1, 4'd4});
        wr_node(3'd3, {1'b0, 4'd0, 1'b0, 4'd0});
        wr_node(3'd4, {1'b0, 4'd8, 1'b1, 4'd0});
        wr_node(3'd5, {1'b0, 4'd0, 1'b0, 4'd0});
        wr_node(3'd6, {1'b0, 4'd0, 1'b0, 4'd0});
        wr_node(3'd7, {1'b0, 4'd0, 1'b0, 4'd0});
        wr_map(2'd0, {1'b0, 4'd5});
        wr_map(2'd1, {1'b0, 4'd4});
        wr_map(2'd2, {1'b1, 4'd3});
        wr_map(2'd3, {1'b1, 4'd15});
        check("cfg_err_idle_writes", 32'(cfg_err), 0);

        start(2'b01, 4'd3, 1'b0);
        finish(lat, ov, errs);
        check("xor01_latency", lat, 5);
        check("xor01_out", 32'(ov), 32'hd);
        handshake();

        start(2'b11, 4'd3, 1'b0);
        finish(lat, ov, errs);
        check("xor11_latency", lat, 5);
        check("xor11_out", 32'(ov), 32'he);
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_vec = 2'b01; num_nodes = 4'd3; in_valid = 1'b1;
            @(negedge clk);
            if (out_vec !== 4'he || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
        end
        in_valid = 1'b0;
        check("hold_stable", 32'(ok), 1);
        handshake();
        check("idle_after_hs_ready", 32'(in_ready), 1);
        check("idle_after_hs_valid", 32'(out_valid), 0);

        start(2'b01, 4'd2, 1'b0);
        finish(lat, ov, errs);
        check("nn2_latency", lat, 4);
        check("nn2_out", 32'(ov), 32'hc);
        handshake();

        start(2'b00, 4'd3, 1'b0);
        finish(lat, ov, errs);
        check("xor00_out", 32'(ov), 32'h8);
        handshake();

        start(2'b01, 4'd15, 1'b0);
        finish(lat, ov, errs);
        check("clamp_latency", lat, 10);
        check("clamp_out", 32'(ov), 32'hd);
`ifdef AIG_EVAL_FWDCHK_EN
        check("fwd_err_pulses", errs, 1);
`else
        check("fwd_err_pulses", errs, 0);
`endif
        handshake();

        start(2'b01, 4'd3, 1'b0);
        cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 10'h000;
        err_cnt = 0; lat = 1;
        @(negedge clk);
        cfg_we = 1'b0; lat = 2; err_cnt += int'(cfg_err);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
            err_cnt += int'(cfg_err);
        end
        check("eval_we_err_cycles", err_cnt, 1);
        check("eval_we_latency", lat, 5);
        check("eval_we_out", 32'(out_vec), 32'hd);
        map_we = 1'b1; map_addr = 2'd0; map_data = 5'd0;
        @(negedge clk);
        map_we = 1'b0;
        check("hold_map_we_err", 32'(cfg_err), 1);
        @(negedge clk);
        check("hold_map_we_err_clear", 32'(cfg_err), 0);
        handshake();

        start(2'b01, 4'd3, 1'b1);
        finish(lat, ov, errs);
        check("accept_we_err", errs, 1);
        check("accept_we_out", 32'(ov), 32'hd);
        handshake();
        start(2'b01, 4'd3, 1'b0);
        finish(lat, ov, errs);
        check("mem_unchanged_out", 32'(ov), 32'hd);
        handshake();

        start(2'b01, 4'd15, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_out_vec", 32'(out_vec), 0);
        check("midrst_cfg_err", 32'(cfg_err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 1);
        start(2'b11, 4'd3, 1'b0);
        finish(lat, ov, errs);
        check("postrst_latency", lat, 5);
        check("postrst_out", 32'(ov), 32'he);
        handshake();

        wr_map(2'd0, {1'b0, 4'd1});
        wr_map(2'd1, {1'b1, 4'd0});
        start(2'b01, 4'd0, 1'b0);
        finish(lat, ov, errs);
        check("nn0_latency", lat, 2);
        check("nn0_out_low", 32'(ov[1:0]), 32'h3);
        check("nn0_out_full", 32'(ov), 32'hf);
        handshake();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
